// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared types for the UART FIFO controller: serial engine state
// encodings and the FIFO occupancy width helper.
package uart_fifo_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Occupancy needs one bit more than the pointer so "full" is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Fabric-side byte streams, occupancy levels and sticky status of the
// UART FIFO controller. master = host fabric, slave = controller.
interface uart_fifo_ctrl_if
    import uart_fifo_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int RX_LW     = level_width(16),
    parameter int TX_LW     = level_width(16)
);
    logic                 loopback_en;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [RX_LW-1:0]     rx_level;
    logic [TX_LW-1:0]     tx_level;
    logic                 rx_overrun;
    logic                 frame_err;
    logic                 status_clr;

    modport master (
        output loopback_en, tx_data, tx_valid, rx_ready, status_clr,
        input  tx_ready, rx_data, rx_valid, rx_level, tx_level, rx_overrun, frame_err
    );

    modport slave (
        input  loopback_en, tx_data, tx_valid, rx_ready, status_clr,
        output tx_ready, rx_data, rx_valid, rx_level, tx_level, rx_overrun, frame_err
    );
endinterface

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Read and write may happen in
// the same cycle at any level; a write into a full FIFO succeeds only when
// a read frees the slot in that same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic               rd,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_cnt_r;
    logic [AW:0]      rd_cnt_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign empty = (wr_cnt_r == rd_cnt_r);
    assign full  = (wr_cnt_r[AW-1:0] == rd_cnt_r[AW-1:0]) && (wr_cnt_r[AW] != rd_cnt_r[AW]);
    assign level = wr_cnt_r - rd_cnt_r;
    assign rdata = mem_r[rd_cnt_r[AW-1:0]];

    // Qualify requests: reads need data, writes need room or a same-cycle read.
    always_comb begin
        rd_ok_s = rd & ~empty;
        wr_ok_s = wr & (~full | rd_ok_s);
    end

    // Advance the free-running write/read counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_r <= '0;
            rd_cnt_r <= '0;
        end else begin
            if (wr_ok_s) wr_cnt_r <= wr_cnt_r + (AW+1)'(1);
            else         wr_cnt_r <= wr_cnt_r;
            if (rd_ok_s) rd_cnt_r <= rd_cnt_r + (AW+1)'(1);
            else         rd_cnt_r <= rd_cnt_r;
        end
    end

    // Store accepted write data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (wr_ok_s) begin
            mem_r[wr_cnt_r[AW-1:0]] <= wdata;
        end else begin
            mem_r <= mem_r;
        end
    end
endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART controller at the chip pins: serial RX/TX engines, RX and TX FIFOs,
// host or internal-loopback routing, sticky overrun/framing status.
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx,
    uart_fifo_ctrl_if.slave bus
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int RX_LW = level_width(RX_DEPTH);
    localparam int TX_LW = level_width(TX_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rx_meta_r, rx_sync_r, lb_r, ready_en_r, overrun_r, ferr_r, tx_r;

    rx_state_t            rx_state_r, rx_state_s;
    logic [CW-1:0]        rx_cnt_r, rx_cnt_s;
    logic [BW-1:0]        rx_bit_r, rx_bit_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
    logic                 rx_push_s, rx_ferr_s;

    tx_state_t            tx_state_r, tx_state_s;
    logic [CW-1:0]        tx_cnt_r, tx_cnt_s;
    logic [BW-1:0]        tx_bit_r, tx_bit_s;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
    logic                 tx_pop_s, tx_s;

    logic                 rx_wr_s, rx_rd_s, rx_full_s, rx_empty_s;
    logic                 tx_wr_s, tx_full_s, tx_empty_s, xfer_s;
    logic                 tx_ready_s, rx_valid_s;
    logic [DATA_BITS-1:0] rx_rdata_s, tx_rdata_s, tx_wdata_s;
    logic [RX_LW-1:0]     rx_level_s;
    logic [TX_LW-1:0]     tx_level_s;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .wr(rx_wr_s), .rd(rx_rd_s), .wdata(rx_shift_r),
        .rdata(rx_rdata_s), .full(rx_full_s), .empty(rx_empty_s), .level(rx_level_s)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .wr(tx_wr_s), .rd(tx_pop_s), .wdata(tx_wdata_s),
        .rdata(tx_rdata_s), .full(tx_full_s), .empty(tx_empty_s), .level(tx_level_s)
    );

    // A received byte is dropped, not queued, whenever the RX FIFO is full.
    assign rx_wr_s    = rx_push_s & ~rx_full_s;
    assign tx_ready_s = ready_en_r & ~lb_r & ~tx_full_s;
    assign rx_valid_s = ~lb_r & ~rx_empty_s;

    assign tx             = tx_r;
    assign bus.tx_ready   = tx_ready_s;
    assign bus.rx_valid   = rx_valid_s;
    assign bus.rx_data    = rx_rdata_s;
    assign bus.rx_level   = rx_level_s;
    assign bus.tx_level   = tx_level_s;
    assign bus.rx_overrun = overrun_r;
    assign bus.frame_err  = ferr_r;

    // Synchronise the pin, register the mode select and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            lb_r       <= 1'b0;
            ready_en_r <= 1'b0;
        end else begin
            rx_meta_r  <= rx;
            rx_sync_r  <= rx_meta_r;
            lb_r       <= bus.loopback_en;
            ready_en_r <= 1'b1;
        end
    end

    // Route FIFO traffic: host handshakes, or RX-to-TX copy in loopback.
    always_comb begin
        xfer_s     = 1'b0;
        rx_rd_s    = 1'b0;
        tx_wr_s    = 1'b0;
        tx_wdata_s = bus.tx_data;
        if (lb_r) begin
            xfer_s     = ~rx_empty_s & ~tx_full_s;
            rx_rd_s    = xfer_s;
            tx_wr_s    = xfer_s;
            tx_wdata_s = rx_rdata_s;
        end else begin
            rx_rd_s    = bus.rx_ready & rx_valid_s;
            tx_wr_s    = bus.tx_valid & tx_ready_s;
        end
    end

    // RX engine next state: mid-bit sampling with start-glitch rejection.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_push_s  = 1'b0;
        rx_ferr_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_s = '0;
                if (!rx_sync_r) rx_state_s = RX_START;
                else            rx_state_s = RX_IDLE;
            end
            RX_START: begin
                if (rx_cnt_r == HALF_END) begin
                    rx_cnt_s = '0;
                    rx_bit_s = '0;
                    if (!rx_sync_r) rx_state_s = RX_DATA;
                    else            rx_state_s = RX_IDLE;
                end else begin
                    rx_cnt_s = rx_cnt_r + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_END) begin
                    rx_cnt_s   = '0;
                    rx_shift_s = {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_bit_r == LAST_BIT) rx_state_s = RX_STOP;
                    else                      rx_bit_s   = rx_bit_r + BW'(1);
                end else begin
                    rx_cnt_s = rx_cnt_r + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_END) begin
                    rx_cnt_s   = '0;
                    rx_state_s = RX_IDLE;
                    if (rx_sync_r) rx_push_s = 1'b1;
                    else           rx_ferr_s = 1'b1;
                end else begin
                    rx_cnt_s = rx_cnt_r + CW'(1);
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
                rx_cnt_s   = '0;
            end
        endcase
    end

    // TX engine next state: pop on frame start, chain frames without idle gap.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_s = '0;
                if (!tx_empty_s) begin
                    tx_state_s = TX_START;
                    tx_shift_s = tx_rdata_s;
                    tx_pop_s   = 1'b1;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s   = '0;
                    tx_bit_s   = '0;
                    tx_state_s = TX_DATA;
                end else begin
                    tx_cnt_s = tx_cnt_r + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s   = '0;
                    tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                    if (tx_bit_r == LAST_BIT) tx_state_s = TX_STOP;
                    else                      tx_bit_s   = tx_bit_r + BW'(1);
                end else begin
                    tx_cnt_s = tx_cnt_r + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s = '0;
                    if (!tx_empty_s) begin
                        tx_state_s = TX_START;
                        tx_shift_s = tx_rdata_s;
                        tx_pop_s   = 1'b1;
                    end else begin
                        tx_state_s = TX_IDLE;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CW'(1);
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_cnt_s   = '0;
            end
        endcase
    end

    // Line level for the state being entered, so the pin is a clean flop output.
    always_comb begin
        case (tx_state_s)
            TX_START: tx_s = 1'b0;
            TX_DATA:  tx_s = tx_shift_s[0];
            default:  tx_s = 1'b1;
        endcase
    end

    // Engine state registers and the registered serial output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= '0;
            rx_shift_r <= '0;
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= '0;
            tx_shift_r <= '0;
            tx_r       <= 1'b1;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_r       <= tx_s;
        end
    end

    // Sticky status; a new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_r <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            if (rx_push_s & rx_full_s) overrun_r <= 1'b1;
            else if (bus.status_clr)   overrun_r <= 1'b0;
            else                       overrun_r <= overrun_r;
            if (rx_ferr_s)             ferr_r    <= 1'b1;
            else if (bus.status_clr)   ferr_r    <= 1'b0;
            else                       ferr_r    <= ferr_r;
        end
    end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Randomised self-checking bench for uart_fifo_ctrl against a queue-based
// reference model and a line monitor that decodes frames from the tx pin.
module tb_uart_fifo_ctrl;
    import uart_fifo_pkg::*;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int RXD   = 4;
    localparam int TXD   = 4;
    localparam int SLOTS = DB + 2;

    typedef logic [DB-1:0] data_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic tx;

    uart_fifo_ctrl_if #(.DATA_BITS(DB), .RX_LW(level_width(RXD)), .TX_LW(level_width(TXD))) bus ();

    uart_fifo_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int b2b_cnt = 0;
    bit rv_watch = 1'b0;
    bit rv_seen  = 1'b0;

    data_t exp_tx_q[$];
    data_t got_tx_q[$];
    bit    got_bad_q[$];
    data_t rx_model_q[$];
    bit    ov_model = 1'b0;
    bit    fe_model = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rv_watch && bus.rx_valid === 1'b1) rv_seen = 1'b1;

    // Line monitor: decodes each frame, checks every bit is constant for CPB cycles.
    initial begin : tx_mon
        int    last_end;
        data_t b;
        bit    bad, aborted;
        logic  v;
        last_end = -10;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                if (cyc == last_end + 1) b2b_cnt++;
                b = '0; bad = 1'b0; aborted = 1'b0; v = 1'b0;
                for (int slot = 0; slot < SLOTS && !aborted; slot++) begin
                    for (int s = 0; s < CPB && !aborted; s++) begin
                        if (!(slot == 0 && s == 0)) @(negedge clk);
                        if (rst !== 1'b1) aborted = 1'b1;
                        else if (s == 0) begin
                            v = tx;
                            if (slot == 0 && tx !== 1'b0) bad = 1'b1;
                            if (slot == SLOTS - 1 && tx !== 1'b1) bad = 1'b1;
                            if (slot >= 1 && slot <= DB) b[slot-1] = tx;
                        end else if (tx !== v) bad = 1'b1;
                    end
                end
                if (!aborted) begin
                    got_tx_q.push_back(b);
                    got_bad_q.push_back(bad);
                    last_end = cyc;
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input data_t d);
        bit ok = 1'b0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (bus.tx_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        check_eq("push_accept", 32'(ok), 32'd1);
        if (ok) exp_tx_q.push_back(d);
    endtask

    // Drive one frame on rx; the model decides where the byte should end up.
    task automatic send_frame(input data_t d, input bit stop, input int stop_len);
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            wait_cycles(CPB);
        end
        rx = stop;
        wait_cycles(stop_len);
        rx = 1'b1;
        if (!stop) fe_model = 1'b1;
        else if (bus.loopback_en) exp_tx_q.push_back(d);
        else if (rx_model_q.size() < RXD) rx_model_q.push_back(d);
        else ov_model = 1'b1;
    endtask

    task automatic rx_pop(input string tag);
        data_t e;
        e = rx_model_q.pop_front();
        check_eq({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(bus.rx_data), 32'(e));
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic compare_tx(input string tag);
        data_t g, e;
        for (int i = 0; i < 20 * CPB * SLOTS && got_tx_q.size() < exp_tx_q.size(); i++) @(negedge clk);
        check_eq({tag, "_count"}, 32'(got_tx_q.size()), 32'(exp_tx_q.size()));
        while (got_tx_q.size() > 0 && exp_tx_q.size() > 0) begin
            g = got_tx_q.pop_front();
            e = exp_tx_q.pop_front();
            check_eq({tag, "_byte"}, 32'(g), 32'(e));
            check_eq({tag, "_shape"}, 32'(got_bad_q.pop_front()), 32'd0);
        end
        got_tx_q.delete(); got_bad_q.delete(); exp_tx_q.delete();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        int n, b2b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
        bus.loopback_en = 1'b0; bus.status_clr = 1'b0;
        wait_cycles(3);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_eq("rst_rx_level", 32'(bus.rx_level), 32'd0);
        check_eq("rst_tx_level", 32'(bus.tx_level), 32'd0);
        check_eq("rst_flags", 32'({bus.rx_overrun, bus.frame_err}), 32'd0);
        check_eq("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        rst = 1'b1;
        wait_cycles(2);
        check_eq("post_rst_tx_ready", 32'(bus.tx_ready), 32'd1);

        // Host TX of 0xA5: level 1 while idle, 0 once the start bit begins.
        push_tx(8'hA5);
        check_eq("tx_level_queued", 32'(bus.tx_level), 32'd1);
        wait_cycles(1);
        check_eq("tx_level_started", 32'(bus.tx_level), 32'd0);
        check_eq("tx_start_low", 32'(tx), 32'd0);
        compare_tx("tx_a5");

        // Back-to-back random frames must chain without idle gaps.
        b2b0 = b2b_cnt;
        for (int i = 0; i < TXD; i++) push_tx(data_t'($urandom));
        compare_tx("tx_burst");
        check_eq("tx_b2b", 32'(b2b_cnt - b2b0), 32'(TXD - 1));

        // Host RX of 0x3C.
        send_frame(8'h3C, 1'b1, CPB);
        wait_cycles(4);
        check_eq("rx3c_level", 32'(bus.rx_level), 32'd1);
        check_eq("rx3c_ferr", 32'(bus.frame_err), 32'd0);
        rx_pop("rx3c");
        check_eq("rx3c_popped", 32'(bus.rx_valid), 32'd0);

        // Random RX bursts.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) send_frame(data_t'($urandom), 1'b1, CPB);
            wait_cycles(4);
            check_eq("rxr_level", 32'(bus.rx_level), 32'(rx_model_q.size()));
            while (rx_model_q.size() > 0) rx_pop("rxr");
        end

        // Overrun with a 4-deep RX FIFO.
        for (int i = 0; i < RXD + 1; i++) send_frame(data_t'($urandom), 1'b1, CPB);
        wait_cycles(4);
        check_eq("ovr_level", 32'(bus.rx_level), 32'(rx_model_q.size()));
        check_eq("ovr_flag", 32'(bus.rx_overrun), 32'(ov_model));
        while (rx_model_q.size() > 0) rx_pop("ovr");
        bus.status_clr = 1'b1; wait_cycles(1); bus.status_clr = 1'b0; ov_model = 1'b0;
        wait_cycles(1);
        check_eq("ovr_cleared", 32'(bus.rx_overrun), 32'(ov_model));

        // Framing error: stop bit low through its sample point.
        send_frame(8'h55, 1'b0, CPB / 2 + 4);
        wait_cycles(2 * CPB);
        check_eq("ferr_flag", 32'(bus.frame_err), 32'(fe_model));
        check_eq("ferr_level", 32'(bus.rx_level), 32'(rx_model_q.size()));
        bus.status_clr = 1'b1; wait_cycles(1); bus.status_clr = 1'b0; fe_model = 1'b0;
        wait_cycles(1);
        check_eq("ferr_cleared", 32'(bus.frame_err), 32'(fe_model));

        // Half-bit glitch on rx is not a start bit.
        rx = 1'b0; wait_cycles(CPB / 2); rx = 1'b1;
        wait_cycles(2 * CPB);
        check_eq("glitch_level", 32'(bus.rx_level), 32'd0);
        check_eq("glitch_ferr", 32'(bus.frame_err), 32'd0);

        // Loopback: received bytes reappear on tx, host side stays quiet.
        bus.loopback_en = 1'b1;
        wait_cycles(2);
        check_eq("lb_tx_ready", 32'(bus.tx_ready), 32'd0);
        rv_watch = 1'b1;
        send_frame(8'h11, 1'b1, CPB);
        send_frame(8'h22, 1'b1, CPB);
        send_frame(8'h33, 1'b1, CPB);
        compare_tx("lb");
        rv_watch = 1'b0;
        check_eq("lb_rx_valid_quiet", 32'(rv_seen), 32'd0);
        bus.loopback_en = 1'b0;
        wait_cycles(2);

        // Reset in the middle of data bit 3 with another byte queued.
        push_tx(data_t'($urandom));
        push_tx(data_t'($urandom));
        for (int i = 0; i < 100 && tx !== 1'b0; i++) @(negedge clk);
        check_eq("mid_start_seen", 32'(tx), 32'd0);
        wait_cycles(4 * CPB + CPB / 2);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_tx", 32'(tx), 32'd1);
        check_eq("mid_rst_tx_level", 32'(bus.tx_level), 32'd0);
        check_eq("mid_rst_rx_level", 32'(bus.rx_level), 32'd0);
        exp_tx_q.delete();
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(2);
        check_eq("mid_post_tx_ready", 32'(bus.tx_ready), 32'd1);
        push_tx(8'h81);
        compare_tx("tx_81");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
